tag_lookup_ctrl: RTL and testbench

- Controller/arbiter for the two tag RAMs (way 0, way 1) of the 2-way L1 cache with MSI coherence.
- Shares the single address port of the tag-RAM pair between three requesters: the CPU lookup path, the bus snoop path, and the cache-controller state update path.
- Sequences the 1-cycle synchronous-read RAMs and compares tags. Returns hit, way, MSI state and replacement victim.
- Holds a per-set LRU bit.

---
 rtl/tag_lookup_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_tag_lookup_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_lookup_ctrl.sv
// Arbitrated tag-RAM sequencer for a 2-way MSI L1: upd > snp > cpu (TAGCTL_RR_EN: snp/cpu round-robin).
// Latency: lookup ack -> rsp_valid 3 cycles; write ack -> RAM written at end of next cycle.
// Backpressure: requesters hold req until their 1-cycle ack; no grant while busy.
module tag_lookup_ctrl #(
    parameter  int AWIDTH = 3,
    parameter  int DWIDTH = 16,
    localparam int TAG_W  = DWIDTH - 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [AWIDTH-1:0] cpu_index,
    input  logic [TAG_W-1:0]  cpu_tag,
    output logic              cpu_ack,
    input  logic              snp_req,
    input  logic [AWIDTH-1:0] snp_index,
    input  logic [TAG_W-1:0]  snp_tag,
    output logic              snp_ack,
    input  logic              upd_req,
    input  logic [AWIDTH-1:0] upd_index,
    input  logic              upd_way,
    input  logic [1:0]        upd_state,
    input  logic [TAG_W-1:0]  upd_tag,
    output logic              upd_ack,
    output logic              rsp_valid,
    output logic              rsp_src,
    output logic              rsp_hit,
    output logic              rsp_way,
    output logic [1:0]        rsp_state,
    output logic              rsp_victim,
    output logic              rsp_multi_hit,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we0,
    output logic              ram_we1,
    input  logic [DWIDTH-1:0] ram_dout0,
    input  logic [DWIDTH-1:0] ram_dout1,
    output logic              busy
);
    localparam int SETS = 1 << AWIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_ISSUE, S_CMP, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                gnt_upd, gnt_snp, gnt_cpu;
    logic                cpu_wins_tie;
    logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DWIDTH-1:0]   ram_din_q, ram_din_d;
    logic                ram_we0_q, ram_we0_d, ram_we1_q, ram_we1_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                src_q, src_d;
    logic                upd_way_q, upd_way_d;
    logic                rsp_src_q, rsp_src_d, rsp_hit_q, rsp_hit_d;
    logic                rsp_way_q, rsp_way_d, rsp_victim_q, rsp_victim_d;
    logic                rsp_multi_q, rsp_multi_d;
    logic [1:0]          rsp_state_q, rsp_state_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic                vld0, vld1, hit0, hit1;

    function automatic logic entry_valid(input logic [1:0] st);
        return (st == 2'b01) || (st == 2'b10);
    endfunction

`ifdef TAGCTL_RR_EN
    logic rr_cpu_q, rr_cpu_d;

    always_comb begin
        rr_cpu_d = rr_cpu_q;
        if (gnt_snp)      rr_cpu_d = 1'b1;
        else if (gnt_cpu) rr_cpu_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rr_cpu_q <= 1'b0;
        else       rr_cpu_q <= rr_cpu_d;
    end

    assign cpu_wins_tie = rr_cpu_q;
`else
    assign cpu_wins_tie = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_upd)                 state_d = S_WR;
                else if (gnt_snp || gnt_cpu) state_d = S_ISSUE;
            end
            S_WR:    state_d = S_IDLE;
            S_ISSUE: state_d = S_CMP;
            S_CMP:   state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Acks are combinational so the requester's fields are sampled in the grant cycle.
    always_comb begin
        gnt_upd = 1'b0;
        gnt_snp = 1'b0;
        gnt_cpu = 1'b0;
        if (state_q == S_IDLE && !reset) begin
            if (upd_req)                 gnt_upd = 1'b1;
            else if (snp_req && cpu_req) begin
                gnt_cpu = cpu_wins_tie;
                gnt_snp = !cpu_wins_tie;
            end
            else if (snp_req)            gnt_snp = 1'b1;
            else if (cpu_req)            gnt_cpu = 1'b1;
        end
        upd_ack   = gnt_upd;
        snp_ack   = gnt_snp;
        cpu_ack   = gnt_cpu;
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_RESP);
    end

    always_comb begin
        vld0 = entry_valid(ram_dout0[DWIDTH-1 -: 2]);
        vld1 = entry_valid(ram_dout1[DWIDTH-1 -: 2]);
        hit0 = vld0 && (ram_dout0[TAG_W-1:0] == tag_q);
        hit1 = vld1 && (ram_dout1[TAG_W-1:0] == tag_q);
    end

    always_comb begin
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_we0_d    = 1'b0;
        ram_we1_d    = 1'b0;
        tag_d        = tag_q;
        src_d        = src_q;
        upd_way_d    = upd_way_q;
        rsp_src_d    = rsp_src_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_way_d    = rsp_way_q;
        rsp_state_d  = rsp_state_q;
        rsp_victim_d = rsp_victim_q;
        rsp_multi_d  = rsp_multi_q;
        lru_d        = lru_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_upd) begin
                    ram_addr_d = upd_index;
                    ram_din_d  = {upd_state, upd_tag};
                    ram_we0_d  = !upd_way;
                    ram_we1_d  = upd_way;
                    upd_way_d  = upd_way;
                end else if (gnt_snp) begin
                    ram_addr_d = snp_index;
                    tag_d      = snp_tag;
                    src_d      = 1'b1;
                end else if (gnt_cpu) begin
                    ram_addr_d = cpu_index;
                    tag_d      = cpu_tag;
                    src_d      = 1'b0;
                end
            end
            S_WR: lru_d[ram_addr_q] = !upd_way_q;
            S_CMP: begin
                rsp_src_d   = src_q;
                rsp_hit_d   = hit0 | hit1;
                rsp_multi_d = hit0 & hit1;
                rsp_way_d   = !hit0 && hit1;
                rsp_state_d = hit0 ? ram_dout0[DWIDTH-1 -: 2] :
                              hit1 ? ram_dout1[DWIDTH-1 -: 2] : 2'b00;
                // Fill an invalid way first; only a fully valid set consults LRU.
                rsp_victim_d = !vld0 ? 1'b0 : !vld1 ? 1'b1 : lru_q[ram_addr_q];
            end
            S_RESP: begin
                if (!rsp_src_q && rsp_hit_q) lru_d[ram_addr_q] = !rsp_way_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_we0_q    <= 1'b0;
            ram_we1_q    <= 1'b0;
            tag_q        <= '0;
            src_q        <= 1'b0;
            upd_way_q    <= 1'b0;
            rsp_src_q    <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= 1'b0;
            rsp_state_q  <= 2'b00;
            rsp_victim_q <= 1'b0;
            rsp_multi_q  <= 1'b0;
            lru_q        <= '0;
        end else begin
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_we0_q    <= ram_we0_d;
            ram_we1_q    <= ram_we1_d;
            tag_q        <= tag_d;
            src_q        <= src_d;
            upd_way_q    <= upd_way_d;
            rsp_src_q    <= rsp_src_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_way_q    <= rsp_way_d;
            rsp_state_q  <= rsp_state_d;
            rsp_victim_q <= rsp_victim_d;
            rsp_multi_q  <= rsp_multi_d;
            lru_q        <= lru_d;
        end
    end

    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign ram_we0       = ram_we0_q;
    assign ram_we1       = ram_we1_q;
    assign rsp_src       = rsp_src_q;
    assign rsp_hit       = rsp_hit_q;
    assign rsp_way       = rsp_way_q;
    assign rsp_state     = rsp_state_q;
    assign rsp_victim    = rsp_victim_q;
    assign rsp_multi_hit = rsp_multi_q;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: directed vector table, arbitration/reset sequences, randomized ops vs a set/way model.
module tb_tag_lookup_ctrl;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int TW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, snp_req = 1'b0, upd_req = 1'b0;
    logic [AW-1:0] cpu_index = '0, snp_index = '0, upd_index = '0;
    logic [TW-1:0] cpu_tag = '0, snp_tag = '0, upd_tag = '0;
    logic          upd_way = 1'b0;
    logic [1:0]    upd_state = 2'b00;
    logic          cpu_ack, snp_ack, upd_ack;
    logic          rsp_valid, rsp_src, rsp_hit, rsp_way, rsp_victim, rsp_multi_hit;
    logic [1:0]    rsp_state;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we0, ram_we1, busy;
    logic [DW-1:0] ram_dout0 = '0, ram_dout1 = '0;
    logic [DW-1:0] mem0 [8] = '{default: '0};
    logic [DW-1:0] mem1 [8] = '{default: '0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0]    m_st [2][8];
    logic [TW-1:0] m_tg [2][8];
    logic          m_lru [8];

    typedef struct packed {
        logic       hit;
        logic       way;
        logic [1:0] st;
        logic       vic;
        logic       multi;
    } res_t;

    typedef struct {
        int            op;   // 0 update, 1 cpu lookup, 2 snoop lookup
        int            idx;
        logic          way;
        logic [1:0]    st;
        logic [TW-1:0] tg;
        res_t          exp;
    } vec_t;

    tag_lookup_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_index(cpu_index), .cpu_tag(cpu_tag), .cpu_ack(cpu_ack),
        .snp_req(snp_req), .snp_index(snp_index), .snp_tag(snp_tag), .snp_ack(snp_ack),
        .upd_req(upd_req), .upd_index(upd_index), .upd_way(upd_way), .upd_state(upd_state),
        .upd_tag(upd_tag), .upd_ack(upd_ack),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_state(rsp_state), .rsp_victim(rsp_victim), .rsp_multi_hit(rsp_multi_hit),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we0(ram_we0), .ram_we1(ram_we1),
        .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ram_we0) mem0[ram_addr] <= ram_din;
        if (ram_we1) mem1[ram_addr] <= ram_din;
        ram_dout0 <= mem0[ram_addr];
        ram_dout1 <= mem1[ram_addr];
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic res_t predict(input int idx, input logic [TW-1:0] tg);
        res_t r;
        logic v [2];
        logic h [2];
        for (int w = 0; w < 2; w++) begin
            v[w] = (m_st[w][idx] == 2'b01) || (m_st[w][idx] == 2'b10);
            h[w] = v[w] && (m_tg[w][idx] == tg);
        end
        r.hit   = h[0] | h[1];
        r.multi = h[0] & h[1];
        r.way   = !h[0] && h[1];
        r.st    = h[0] ? m_st[0][idx] : (h[1] ? m_st[1][idx] : 2'b00);
        r.vic   = !v[0] ? 1'b0 : (!v[1] ? 1'b1 : m_lru[idx]);
        return r;
    endfunction

    function automatic void model_upd(input int idx, input logic way, input logic [1:0] st,
                                      input logic [TW-1:0] tg);
        m_st[way][idx] = st;
        m_tg[way][idx] = tg;
        m_lru[idx]     = !way;
    endfunction

    function automatic void model_lookup(input logic src, input int idx, input res_t e);
        if (!src && e.hit) m_lru[idx] = !e.way;
    endfunction

    task automatic do_upd(input int idx, input logic way, input logic [1:0] st, input logic [TW-1:0] tg);
        int n;
        @(negedge clock);
        upd_index = AW'(idx); upd_way = way; upd_state = st; upd_tag = tg; upd_req = 1'b1;
        #1;
        n = 0;
        while (!upd_ack && n < 40) begin @(negedge clock); #1; n++; end
        chk("upd_ack", 32'(upd_ack), 1);
        @(posedge clock); #1;
        upd_req = 1'b0;
        @(negedge clock);
        chk("upd_we0_pulse", 32'(ram_we0), 32'(!way));
        chk("upd_we1_pulse", 32'(ram_we1), 32'(way));
        @(negedge clock);
        chk("upd_we_clear", 32'({ram_we0, ram_we1}), 0);
        model_upd(idx, way, st, tg);
    endtask

    task automatic lookup(input logic src, input int idx, input logic [TW-1:0] tg, output res_t r);
        int n;
        int t0;
        @(negedge clock);
        if (src) begin snp_index = AW'(idx); snp_tag = tg; snp_req = 1'b1; end
        else     begin cpu_index = AW'(idx); cpu_tag = tg; cpu_req = 1'b1; end
        #1;
        n = 0;
        while (!(src ? snp_ack : cpu_ack) && n < 40) begin @(negedge clock); #1; n++; end
        chk("lookup_ack", 32'(src ? snp_ack : cpu_ack), 1);
        t0 = cyc;
        @(posedge clock); #1;
        snp_req = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clock); n++; end
        chk("rsp_latency", cyc - t0, 3);
        chk("rsp_src", 32'(rsp_src), 32'(src));
        r.hit = rsp_hit; r.way = rsp_way; r.st = rsp_state; r.vic = rsp_victim; r.multi = rsp_multi_hit;
        @(negedge clock);
        chk("rsp_one_cycle", 32'(rsp_valid), 0);
    endtask

    task automatic cmp(input string nm, input res_t a, input res_t e);
        chk({nm, ".hit"}, 32'(a.hit), 32'(e.hit));
        if (e.hit) chk({nm, ".way"}, 32'(a.way), 32'(e.way));
        chk({nm, ".state"}, 32'(a.st), 32'(e.st));
        chk({nm, ".victim"}, 32'(a.vic), 32'(e.vic));
        chk({nm, ".multi"}, 32'(a.multi), 32'(e.multi));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_req = 1'b0; snp_req = 1'b0; upd_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
    endtask

    function automatic vec_t mk(input int op, input int idx, input logic way, input logic [1:0] st,
                                input logic [TW-1:0] tg, input logic h, input logic w,
                                input logic [1:0] es, input logic v, input logic m);
        vec_t x;
        x.op = op; x.idx = idx; x.way = way; x.st = st; x.tg = tg;
        x.exp.hit = h; x.exp.way = w; x.exp.st = es; x.exp.vic = v; x.exp.multi = m;
        return x;
    endfunction

    initial begin
        vec_t tbl[$];
        res_t r, e;
        int t_u, t_s, t_c, nacks, ng, ncpu, op, idx;
        logic g [3];
        logic [TW-1:0] tg;
        logic [DW-1:0] old_w1;

        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 8; s++) begin m_st[w][s] = 2'b00; m_tg[w][s] = '0; end

        // op idx way st tag | hit way state victim multi
        tbl.push_back(mk(0, 2, 0, 2'b01, 14'h0A5, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2, 0, 2'b00, 14'h0A5, 1, 0, 2'b01, 1, 0));
        tbl.push_back(mk(0, 5, 1, 2'b10, 14'h123, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 5, 0, 2'b00, 14'h123, 1, 1, 2'b10, 0, 0));
        tbl.push_back(mk(1, 5, 0, 2'b00, 14'h456, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 3, 1, 2'b01, 14'h011, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 3, 0, 2'b01, 14'h022, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 3, 0, 2'b00, 14'h033, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(2, 3, 0, 2'b00, 14'h011, 1, 1, 2'b01, 1, 0));
        tbl.push_back(mk(1, 3, 0, 2'b00, 14'h044, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(1, 3, 0, 2'b00, 14'h011, 1, 1, 2'b01, 1, 0));
        tbl.push_back(mk(1, 3, 0, 2'b00, 14'h044, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 6, 0, 2'b10, 14'h077, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 6, 1, 2'b01, 14'h077, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 6, 0, 2'b00, 14'h077, 1, 0, 2'b10, 0, 1));
        tbl.push_back(mk(1, 6, 0, 2'b00, 14'h055, 0, 0, 2'b00, 1, 0));
        tbl.push_back(mk(0, 7, 0, 2'b11, 14'h099, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 7, 0, 2'b00, 14'h099, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 2, 0, 2'b10, 14'h0A5, 0, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 2, 0, 2'b00, 14'h0A5, 1, 0, 2'b10, 1, 0));
        tbl.push_back(mk(2, 5, 0, 2'b00, 14'h777, 0, 0, 2'b00, 0, 0));

        #2 reset = 1'b1;
        @(negedge clock);
        chk("reset_ctrl_outputs", 32'({cpu_ack, snp_ack, upd_ack, rsp_valid, rsp_src, rsp_hit, rsp_way,
                                     rsp_state, rsp_victim, rsp_multi_hit, ram_we0, ram_we1, busy}), 0);
        chk("reset_ram_addr", 32'(ram_addr), 0);
        chk("reset_ram_din", 32'(ram_din), 0);
        do_reset();

        foreach (tbl[i]) begin
            if (tbl[i].op == 0) begin
                do_upd(tbl[i].idx, tbl[i].way, tbl[i].st, tbl[i].tg);
            end else begin
                lookup(tbl[i].op == 2, tbl[i].idx, tbl[i].tg, r);
                cmp($sformatf("vec%0d", i), r, tbl[i].exp);
                model_lookup(tbl[i].op == 2, tbl[i].idx, predict(tbl[i].idx, tbl[i].tg));
                if (tbl[i].op == 1 && tbl[i].exp.hit) m_lru[tbl[i].idx] = !tbl[i].exp.way;
            end
        end

        // All three requesters raise req in the same cycle.
        @(negedge clock);
        upd_index = 3'd0; upd_way = 1'b0; upd_state = 2'b01; upd_tag = 14'h100;
        snp_index = 3'd0; snp_tag = 14'h100; cpu_index = 3'd0; cpu_tag = 14'h100;
        upd_req = 1'b1; snp_req = 1'b1; cpu_req = 1'b1;
        t_u = -1; t_s = -1; t_c = -1; nacks = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (int'(upd_ack) + int'(snp_ack) + int'(cpu_ack) > 1) nacks++;
            if (upd_ack) t_u = cyc;
            if (snp_ack) t_s = cyc;
            if (cpu_ack) t_c = cyc;
            @(posedge clock); #1;
            if (t_u >= 0) upd_req = 1'b0;
            if (t_s >= 0) snp_req = 1'b0;
            if (t_c >= 0) cpu_req = 1'b0;
            @(negedge clock);
        end
        upd_req = 1'b0; snp_req = 1'b0; cpu_req = 1'b0;
        chk("prio_single_ack", nacks, 0);
        chk("prio_upd_granted", int'(t_u >= 0), 1);
        chk("prio_snp_after_upd", t_s - t_u, 2);
        chk("prio_cpu_after_upd", t_c - t_u, 6);
        model_upd(0, 1'b0, 2'b01, 14'h100);
        m_lru[0] = 1'b1;

        for (int i = 0; i < 80; i++) begin
            op  = $urandom_range(0, 2);
            idx = $urandom_range(0, 7);
            tg  = TW'($urandom_range(0, 3));
            if (op == 0) begin
                do_upd(idx, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), tg);
            end else begin
                e = predict(idx, tg);
                lookup(op == 2, idx, tg, r);
                cmp($sformatf("rand%0d", i), r, e);
                model_lookup(op == 2, idx, e);
            end
        end

        // Reset while a lookup sits in ISSUE.
        @(negedge clock);
        cpu_index = 3'd4; cpu_tag = 14'h001; cpu_req = 1'b1;
        #1;
        ng = 0;
        while (!cpu_ack && ng < 40) begin @(negedge clock); #1; ng++; end
        chk("rst_issue_ack", 32'(cpu_ack), 1);
        @(posedge clock); #1;
        cpu_req = 1'b0;
        chk("rst_issue_busy_before", 32'(busy), 1);
        reset = 1'b1;
        #1;
        chk("rst_issue_outputs", 32'({busy, rsp_valid, ram_we0, ram_we1, cpu_ack, ram_addr}), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rsp_valid || ram_we0 || ram_we1) ng++;
        end
        chk("rst_issue_no_activity", ng, 0);

        // Reset while a write sits in WR.
        old_w1 = mem1[4];
        @(negedge clock);
        upd_index = 3'd4; upd_way = 1'b1; upd_state = 2'b10; upd_tag = 14'h3FF; upd_req = 1'b1;
        #1;
        ng = 0;
        while (!upd_ack && ng < 40) begin @(negedge clock); #1; ng++; end
        chk("rst_wr_ack", 32'(upd_ack), 1);
        @(posedge clock); #1;
        upd_req = 1'b0;
        chk("rst_wr_we_before", 32'(ram_we1), 1);
        reset = 1'b1;
        #1;
        chk("rst_wr_outputs", 32'({busy, rsp_valid, ram_we0, ram_we1, ram_din}), 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (rsp_valid || ram_we0 || ram_we1) ng++;
        end
        chk("rst_wr_no_activity", ng, 0);
        chk("rst_wr_abandoned", int'(mem1[4] == old_w1), 1);
        e = predict(4, 14'h3FF);
        lookup(1'b0, 4, 14'h3FF, r);
        cmp("post_reset", r, e);

        // Continuous snoop and CPU requests from a fresh reset.
        do_reset();
        @(negedge clock);
        snp_index = 3'd1; snp_tag = 14'h003; cpu_index = 3'd1; cpu_tag = 14'h003;
        snp_req = 1'b1; cpu_req = 1'b1;
        ng = 0; ncpu = 0;
        g[0] = 1'b0; g[1] = 1'b0; g[2] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (ng < 3 && (snp_ack || cpu_ack)) begin g[ng] = snp_ack; ng++; end
            if (cpu_ack) ncpu++;
            @(negedge clock);
        end
        snp_req = 1'b0; cpu_req = 1'b0;
        chk("tie_grant_count", ng, 3);
`ifdef TAGCTL_RR_EN
        chk("rr_grant0_snp", 32'(g[0]), 1);
        chk("rr_grant1_cpu", 32'(g[1]), 0);
        chk("rr_grant2_snp", 32'(g[2]), 1);
`else
        chk("fixed_grant0_snp", 32'(g[0]), 1);
        chk("fixed_grant1_snp", 32'(g[1]), 1);
        chk("fixed_grant2_snp", 32'(g[2]), 1);
        chk("fixed_cpu_starved", ncpu, 0);
`endif
        repeat (6) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
